// File: rtl/irq_pending_latch_16_if.sv
// irq_pending_latch_16_if: request/ack/pending bundle between the latch and its driver.
interface irq_pending_latch_16_if;
    logic [15:0] req_in;
    logic [15:0] edge_sel;
    logic [15:0] mask;
    logic        ack_valid;
    logic [3:0]  ack_idx;
    logic        ovr_clr;
    logic [15:0] pend_out;
    logic [15:0] pend_raw;
    logic        any_pend;
    logic [15:0] overrun;
    logic        ack_err;
    modport master (
        output req_in, edge_sel, mask, ack_valid, ack_idx, ovr_clr,
        input  pend_out, pend_raw, any_pend, overrun, ack_err
    );
    modport slave (
        input  req_in, edge_sel, mask, ack_valid, ack_idx, ovr_clr,
        output pend_out, pend_raw, any_pend, overrun, ack_err
    );
endinterface

// File: rtl/irq_pending_latch_16.sv
// irq_pending_latch_16: synchronises 16 request lines into edge/level pending bits with ack clear and overrun flags.
module irq_pending_latch_16 #(
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst_n,
    irq_pending_latch_16_if.slave bus
);
    logic [SYNC_STAGES-1:0][15:0] r_sync;
    logic [15:0] r_req_d;
    logic [15:0] r_pend;
    logic [15:0] r_ovr;
    logic        r_ack_err;
    logic [15:0] w_req_s;
    logic [15:0] w_rise;
    logic [15:0] w_set;
    logic [15:0] w_clr;
    assign w_req_s = r_sync[SYNC_STAGES-1];
    // req_d resets to 0, so a line already high at reset release reads as a rise
    assign w_rise  = w_req_s & ~r_req_d;
    assign w_set   = (bus.edge_sel & w_rise) | (~bus.edge_sel & w_req_s);
    assign w_clr   = bus.ack_valid ? 16'(1) << bus.ack_idx : 16'h0000;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_req_d   <= '0;
            r_pend    <= '0;
            r_ovr     <= '0;
            r_ack_err <= 1'b0;
        end else begin
            r_sync[0] <= bus.req_in;
            for (int j = 1; j < SYNC_STAGES; j++) r_sync[j] <= r_sync[j-1];
            r_req_d   <= w_req_s;
            r_pend    <= w_set | (r_pend & ~w_clr);
            r_ovr     <= (bus.edge_sel & w_rise & r_pend & ~w_clr) | (r_ovr & ~{16{bus.ovr_clr}});
            r_ack_err <= bus.ack_valid & ~r_pend[bus.ack_idx];
        end
    end
    assign bus.pend_raw = r_pend;
    assign bus.pend_out = r_pend & bus.mask;
    assign bus.any_pend = |(r_pend & bus.mask);
    assign bus.overrun  = r_ovr;
    assign bus.ack_err  = r_ack_err;
endmodule
